mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access is in flight at a time; each access takes IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_be,
    input  logic [DATA_W-1:0]   ram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  owner_q;
    logic                  last_owner_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   be_q;

    logic                  grant_any;
    logic                  grant_sel;

    // On contention the requester that did not own the previous access wins.
    always_comb begin
        grant_any = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_sel = ~last_owner_q;
        end else begin
            grant_sel = m1_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_any) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            if (state_q == StIdle && grant_any) begin
                owner_q <= grant_sel;
                we_q    <= grant_sel ? m1_we    : m0_we;
                addr_q  <= grant_sel ? m1_addr  : m0_addr;
                wdata_q <= grant_sel ? m1_wdata : m0_wdata;
                be_q    <= grant_sel ? m1_be    : m0_be;
            end
            if (state_q == StResp) begin
                last_owner_q <= owner_q;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_be    = be_q;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        unique case (state_q)
            StAccess: begin
                ram_en = 1'b1;
                ram_we = we_q;
            end
            StResp: begin
                // RAM read data arrives this cycle; writes return zero.
                if (owner_q) begin
                    m1_ready = 1'b1;
                    m1_rdata = we_q ? '0 : ram_rdata;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = we_q ? '0 : ram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected RAM strobes and ready pulses are queued
// at stimulus time and matched by a negedge monitor, including their cycle numbers.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_be = '0;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_be = '0;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        bit          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    txn_t ram_q[$];
    txn_t resp_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    // RAM model: data valid the cycle after the strobe, for reads and writes alike.
    always @(posedge clk) if (ram_en) ram_rdata <= ram_val(ram_addr);

    function automatic void check(input string tag, input logic [63:0] obs,
                                  input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        txn_t e;
        if (reset) begin
            check("rst_strobes", {ram_en, ram_we, m0_ready, m1_ready}, 0);
        end else begin
            if (ram_en === 1'b1) begin
                if (ram_q.size() == 0) begin
                    check("unexpected_ram_en", ram_en, 0);
                end else begin
                    e = ram_q.pop_front();
                    check("ram_cycle", cyc, e.cyc);
                    check("ram_we", ram_we, e.we);
                    check("ram_addr", ram_addr, e.addr);
                    check("ram_wdata", ram_wdata, e.wdata);
                    check("ram_be", ram_be, e.be);
                end
            end else begin
                check("ram_we_unqualified", ram_we, 0);
                if (ram_q.size() != 0 && ram_q[0].cyc <= cyc) begin
                    check("ram_en_missing", ram_en, 1);
                    void'(ram_q.pop_front());
                end
            end
            check("ready_exclusive", m0_ready & m1_ready, 0);
            if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_ready", m0_ready | m1_ready, 0);
                end else begin
                    e = resp_q.pop_front();
                    check("ready_cycle", cyc, e.cyc);
                    check("ready_m0", m0_ready, !e.port);
                    check("ready_m1", m1_ready, e.port);
                    check("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
                end
            end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
                check("ready_missing", m0_ready | m1_ready, 1);
                void'(resp_q.pop_front());
            end
            if (m0_ready !== 1'b1) check("m0_rdata_idle", m0_rdata, 0);
            if (m1_ready !== 1'b1) check("m1_rdata_idle", m1_rdata, 0);
        end
    end

    task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end
    endtask

    task automatic expect_txn(input int ram_cyc, input bit port, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
        txn_t e;
        e.cyc = ram_cyc; e.port = port; e.we = we; e.addr = addr;
        e.wdata = wdata; e.be = be;
        e.rdata = we ? 32'h0 : ram_val(addr);
        ram_q.push_back(e);
        e.cyc = ram_cyc + 1;
        resp_q.push_back(e);
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns likewise.
    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input bit change);
        expect_txn(cyc + 1, port, we, addr, wdata, be);
        drive(port, 1'b1, we, addr, wdata, be);
        @(posedge clk); #1;
        if (change) drive(port, 1'b0, ~we, addr + 32'h4, ~wdata, ~be);
        @(posedge clk); #1;
        drive(port, 1'b0, we, addr, wdata, be);
        @(posedge clk); #1;
    endtask

    task automatic contend(input bit first, input int n);
        int k = cyc;
        for (int i = 0; i < n; i++) begin
            if (first ^ i[0]) expect_txn(k + 1 + 3 * i, 1'b1, 1'b1, 32'h204, 32'hCAFE0123,
                                         4'b1100);
            else expect_txn(k + 1 + 3 * i, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1111);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b1111);
        drive(1'b1, 1'b1, 1'b1, 32'h204, 32'hCAFE0123, 4'b1100);
        repeat (3 * n - 1) @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {ram_en, ram_we, m0_ready, m1_ready, ram_be, ram_addr}, 0);
        check({tag, "_wdata"}, ram_wdata, 0);
        check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle: nothing may move for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_strobes", {ram_en, m0_ready, m1_ready}, 0);
        end
        @(posedge clk); #1;

        contend(1'b0, 4);
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
        do_access(1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011, 1'b0);
        do_access(1'b0, 1'b1, 32'h40, 32'h55AA55AA, 4'b1111, 1'b1);
        // m0 owned the last access, so m1 must win the next contention.
        contend(1'b1, 2);

        // Reset mid-access: m1 read aborted, then regranted via IDLE.
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'b1111);
        @(posedge clk); #1;
        check("pre_abort_ram_en", ram_en, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        expect_txn(cyc + 1, 1'b1, 1'b0, 32'h300, 32'h0, 4'b1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(posedge clk); #1;

        // last_owner is back at 1 after reset, so m0 wins first.
        contend(1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        check("ram_queue_drained", ram_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
